// File: rtl/mem_stage.sv
// Pipeline memory stage: M pipeline register, byte-addressed little-endian data memory,
// bounds checking and status resolution for the memory-access instructions.
module mem_stage #(
    parameter int MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  e_icode,
    input  logic [1:0]  e_stat,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        e_cnd,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic [3:0]  M_icode,
    output logic [63:0] M_valE,
    output logic [3:0]  M_dstE,
    output logic        M_cnd,
    output logic [3:0]  m_dstM,
    output logic [63:0] m_valM,
    output logic [1:0]  m_stat,
    output logic        dmem_error
);

    localparam int          AW         = $clog2(MEM_BYTES);
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [1:0] S_AOK    = 2'd0;
    localparam logic [1:0] S_ADR    = 2'd2;

    logic [1:0]  M_stat;
    logic [63:0] M_valA;
    logic [3:0]  M_dstM;

    logic [7:0]  mem [MEM_BYTES];

    logic          mem_read;
    logic          mem_write;
    logic          use_valA;
    logic [63:0]   acc_addr;
    logic [AW-1:0] byte_idx [8];
    logic [63:0]   read_data;
    logic          store_commit;

    // M register; stall wins over bubble, reset loads the bubble values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_icode <= I_NOP;
            M_stat  <= S_AOK;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
            M_cnd   <= 1'b0;
        end else if (!m_stall) begin
            if (m_bubble) begin
                M_icode <= I_NOP;
                M_stat  <= S_AOK;
                M_valE  <= '0;
                M_valA  <= '0;
                M_dstE  <= R_NONE;
                M_dstM  <= R_NONE;
                M_cnd   <= 1'b0;
            end else begin
                M_icode <= e_icode;
                M_stat  <= e_stat;
                M_valE  <= e_valE;
                M_valA  <= e_valA;
                M_dstE  <= e_dstE;
                M_dstM  <= e_dstM;
                M_cnd   <= e_cnd;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        use_valA  = 1'b0;
        case (M_icode)
            I_MRMOVQ: mem_read = 1'b1;
            I_RET, I_POPQ: begin
                mem_read = 1'b1;
                use_valA = 1'b1;
            end
            I_RMMOVQ, I_CALL, I_PUSHQ: mem_write = 1'b1;
            default: ;
        endcase
    end

    // Full 64-bit compare so huge addresses never alias back into the array.
    always_comb begin
        acc_addr   = use_valA ? M_valA : M_valE;
        dmem_error = (mem_read || mem_write) && (acc_addr > ADDR_LIMIT);
        for (int i = 0; i < 8; i++) begin
            byte_idx[i] = acc_addr[AW-1:0] + AW'(i);
        end
    end

    always_comb begin
        read_data = '0;
        for (int i = 0; i < 8; i++) begin
            read_data[8*i +: 8] = mem[byte_idx[i]];
        end
    end

    assign m_valM = (mem_read && !dmem_error) ? read_data : 64'd0;
    assign m_stat = dmem_error ? S_ADR : M_stat;
    assign m_dstM = M_dstM;

    assign store_commit = mem_write && !dmem_error && (M_stat == S_AOK) && !rst;

    // Memory has no reset; a held store simply rewrites the same bytes.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < 8; i++) begin
                mem[byte_idx[i]] <= M_valA[8*i +: 8];
            end
        end
    end

endmodule
